ceres_reset_sequencer: RTL and testbench



---
 rtl/ceres_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_ceres_reset_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ceres_reset_sequencer.sv
// ceres_reset_sequencer: board reset sequencer with lock qualification, button debounce and staged release.
// Define CERES_RST_CAUSE_EN to build the sticky reset-cause register; otherwise rst_cause_o is tied to zero.
module ceres_reset_sequencer #(
  parameter int HOLD_CYCLES     = 16,
  parameter int CORE_DELAY      = 8,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       btn_rst_i,
  input  logic       wdt_reset_i,
  input  logic       sw_reset_req_i,
  output logic       periph_rst_no,
  output logic       core_rst_no,
  output logic       rst_active_o,
  output logic [4:0] rst_cause_o,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    RESET      = 3'd0,
    WAIT_LOCK  = 3'd1,
    HOLD       = 3'd2,
    REL_PERIPH = 3'd3,
    RUN        = 3'd4
  } state_e;

  localparam int CW = $clog2((HOLD_CYCLES > CORE_DELAY ? HOLD_CYCLES : CORE_DELAY) + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CORE_LD = CW'(CORE_DELAY - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]    lock_ff_q, lock_ff_d, btn_ff_q, btn_ff_d;
  logic          btn_deb_q, btn_deb_d;
  logic          periph_q, periph_d, core_q, core_d, active_q, active_d;
  logic          deb_mis, deb_flip;
  logic [3:0]    trig;

  always_comb begin
    lock_ff_d = {lock_ff_q[0], pll_locked_i};
    btn_ff_d  = {btn_ff_q[0], btn_rst_i};
    deb_mis   = btn_ff_q[1] != btn_deb_q;
    deb_flip  = deb_mis && deb_cnt_q == DEB_MAX;
    deb_cnt_d = deb_mis && !deb_flip ? deb_cnt_q + DW'(1) : '0;
    btn_deb_d = btn_deb_q ^ deb_flip;
    trig      = {sw_reset_req_i, wdt_reset_i, btn_deb_q, ~lock_ff_q[1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    core_d   = core_q;
    case (state_q)
      RESET: begin
        state_d  = WAIT_LOCK;
        periph_d = 1'b0;
        core_d   = 1'b0;
      end
      WAIT_LOCK: if (lock_ff_q[1] && !btn_deb_q) begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end
      HOLD, REL_PERIPH, RUN: begin
        if (|trig) begin
          // lock loss must wait for relock; every other trigger restarts the hold window
          state_d  = trig[0] ? WAIT_LOCK : HOLD;
          cnt_d    = HOLD_LD;
          periph_d = 1'b0;
          core_d   = 1'b0;
        end else if (state_q != RUN) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d  = state_q == HOLD ? REL_PERIPH : RUN;
            cnt_d    = CORE_LD;
            periph_d = 1'b1;
            core_d   = state_q == REL_PERIPH;
          end
        end
      end
      default: state_d = RESET;
    endcase
    active_d = ~(periph_d & core_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RESET;
      cnt_q     <= '0;
      deb_cnt_q <= '0;
      lock_ff_q <= '0;
      btn_ff_q  <= '0;
      btn_deb_q <= 1'b0;
      periph_q  <= 1'b0;
      core_q    <= 1'b0;
      active_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      deb_cnt_q <= deb_cnt_d;
      lock_ff_q <= lock_ff_d;
      btn_ff_q  <= btn_ff_d;
      btn_deb_q <= btn_deb_d;
      periph_q  <= periph_d;
      core_q    <= core_d;
      active_q  <= active_d;
    end
  end

`ifdef CERES_RST_CAUSE_EN
  logic [4:0] cause_q, cause_d;

  // causes accumulate within one episode; a trigger from RUN starts a fresh record
  always_comb
    cause_d = (state_q inside {HOLD, REL_PERIPH, RUN}) && |trig ?
              ({trig, 1'b0} | (state_q == RUN ? 5'd0 : cause_q)) : cause_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) cause_q <= 5'b00001;
    else       cause_q <= cause_d;
  end

  assign rst_cause_o = cause_q;
`else
  assign rst_cause_o = 5'b00000;
`endif

  assign periph_rst_no = periph_q;
  assign core_rst_no   = core_q;
  assign rst_active_o  = active_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_ceres_reset_sequencer.sv
// tb_ceres_reset_sequencer: directed and random stimulus checked against a timestamp-based reference model.
module tb_ceres_reset_sequencer;
  localparam int H = 4, C = 3, D = 5;

  logic clk = 0, rst = 1, pll = 1, btn = 0, wdt = 0, sw = 0;
  logic periph, core, active;
  logic [4:0] cause;
  logic [2:0] state;
  int total = 0, bad = 0;

  // model: episode described by "waiting for lock" and the edge at which the hold window last started
  int n = 0, hs = 0;
  bit por = 1, waiting = 1, deb = 0;
  bit [1:0] lk_p = 0, bt_p = 0;
  bit hist[$];
  logic [4:0] cause_m = 5'b00001;

  ceres_reset_sequencer #(.HOLD_CYCLES(H), .CORE_DELAY(C), .DEBOUNCE_CYCLES(D)) dut (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .btn_rst_i(btn),
    .wdt_reset_i(wdt), .sw_reset_req_i(sw), .periph_rst_no(periph),
    .core_rst_no(core), .rst_active_o(active), .rst_cause_o(cause), .state_o(state));

  always #5 clk = ~clk;

  function automatic int st_at(int m);
    return por ? 0 : waiting ? 1 : m < hs + H ? 2 : m < hs + H + C ? 3 : 4;
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at edge %0d", tag, obs, exp, n);
    end
  endtask

  function automatic logic [4:0] exp_cause();
`ifdef CERES_RST_CAUSE_EN
    return cause_m;
`else
    return 5'b00000;
`endif
  endfunction

  task automatic step();
    logic [3:0] tr;
    int ps, s;
    bit all_diff;
    @(posedge clk);
    n++;
    if (rst) begin
      por = 1; waiting = 1; lk_p = 0; bt_p = 0; deb = 0; hist.delete(); cause_m = 5'b00001;
    end else begin
      tr = {sw, wdt, deb, ~lk_p[1]};
      ps = st_at(n - 1);
      if (por) por = 0;
      else if (waiting) begin
        if (lk_p[1] && !deb) begin waiting = 0; hs = n; end
      end else if (tr != 0) begin
        cause_m = {tr, 1'b0} | (ps != 4 ? cause_m : 5'd0);
        if (tr[0]) waiting = 1; else hs = n;
      end
      hist.push_back(bt_p[1]);
      if (hist.size() > D) void'(hist.pop_front());
      all_diff = hist.size() == D;
      foreach (hist[k]) if (hist[k] == deb) all_diff = 0;
      if (all_diff) begin deb = ~deb; hist.delete(); end
      lk_p = {lk_p[0], pll};
      bt_p = {bt_p[0], btn};
    end
    #1;
    s = st_at(n);
    chk("state", 5'(state), 5'(s));
    chk("periph", 5'(periph), 5'(s >= 3));
    chk("core", 5'(core), 5'(s == 4));
    chk("active", 5'(active), 5'(s != 4));
    chk("cause", cause, exp_cause());
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic pulse(input bit w, input bit s);
    wdt = w; sw = s;
    step();
    wdt = 0; sw = 0;
  endtask

  initial begin
    run(3);
    chk("por_state", 5'(state), 5'd0);
    chk("por_active", 5'(active), 5'd1);
    rst = 0;
    run(20);
    chk("por_run", 5'(state), 5'd4);
`ifdef CERES_RST_CAUSE_EN
    chk("por_cause", cause, 5'b00001);
`endif
    pulse(1, 0);
    chk("wdt_assert", 5'({periph, core}), 5'd0);
`ifdef CERES_RST_CAUSE_EN
    chk("wdt_cause", cause, 5'b01000);
`endif
    run(12);
    pll = 0;
    run(10);
    pll = 1;
    run(20);
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      run(2);
    end
    chk("bounce_run", 5'(state), 5'd4);
    btn = 0;
    run(8);
    btn = 1;
    run(8);
    btn = 0;
    chk("btn_assert", 5'(periph), 5'd0);
    run(25);
    pulse(1, 1);
`ifdef CERES_RST_CAUSE_EN
    chk("simul_cause", cause, 5'b11000);
`endif
    run(12);
    pulse(0, 1);
    run(2);
    pulse(0, 1);
    run(3);
    chk("retrig_hold", 5'(periph), 5'd0);
    run(1);
    chk("retrig_rel", 5'(periph), 5'd1);
    run(6);
    for (int i = 0; i < 500; i++) begin
      rst = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 39) == 0) pll = ~pll;
      if ($urandom_range(0, 14) == 0) btn = ~btn;
      wdt = $urandom_range(0, 29) == 0;
      sw = $urandom_range(0, 29) == 0;
      step();
    end
    rst = 0; pll = 1; btn = 0; wdt = 0; sw = 0;
    run(30);
    chk("final_run", 5'(state), 5'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
